serial_addsub: RTL
==================

# serial_addsub

Multi-cycle, bit-serial 64-bit add/subtract unit for the Execute-stage ALU. It processes operands LSB-first through a single full-adder cell, one bit per clock, and produces the Y86-64 condition codes. It is the area-minimal sequential counterpart to the parallel ripple ADDSUB path and sits beside it in the Execute stage under a start/done handshake.

## Interface
- `WIDTH`, default 64: operand and result width in bits; must be ≥ 2.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request a new operation; sampled only while `ready`=1.
- `op` input, 1 bit: 0 = add (a + b); 1 = subtract (a − b, computed as a + ~b + 1).
- `a` input, WIDTH bits: first operand, latched on the accepting edge.
- `b` input, WIDTH bits: second operand, latched on the accepting edge.
- `ready` output, 1 bit: unit idle, `start` will be accepted.
- `busy` output, 1 bit: operation in progress (RUN state).
- `done` output, 1 bit: one-cycle pulse; `result`, `cc` and `c_out` were updated on the same edge.
- `result` output, WIDTH bits: last completed result.
- `cc` output, 3 bits: {ZF, SF, OF} of the last completed result.
- `c_out` output, 1 bit: carry out of the MSB stage. For subtract, 1 means no borrow.

## Operation
- FSM states: IDLE, RUN, DONE. `ready` = (state==IDLE), `busy` = (state==RUN), `done` = (state==DONE).
- IDLE → RUN on an edge with `start`=1. On that edge:
  - `a` and `op ? ~b : b` load into internal shift registers.
  - Carry flop loads `op`.
  - Bit counter clears to 0.
- RUN, every edge:
  - Serial sum bit = a0 ^ b0 ^ carry. Carry ← majority(a0, b0, carry).
  - Both operand registers shift right by 1.
  - Sum bit shifts into the MSB of the internal accumulator.
  - Counter increments.
- RUN → DONE on the edge that processes bit WIDTH−1 (counter == WIDTH−1). On that same edge:
  - `result` ← final accumulator value.
  - `c_out` ← final carry.
  - ZF ← (result == 0).
  - SF ← result[WIDTH−1].
  - OF ← carry into MSB stage XOR carry out of MSB stage.
- DONE → IDLE unconditionally on the next edge.
- `result`, `cc` and `c_out` hold their values at all other times. They do not change during RUN and are updated only on the DONE-entering edge.
- `start` is ignored in RUN and DONE; it is not queued.
- Arithmetic is modulo 2^WIDTH. No saturation, no exceptions.

## Timing
- Reset (`rst_n`=0, asynchronous, immediate): state=IDLE, `ready`=1, `busy`=0, `done`=0, `result`=0, `cc`=3'b000, `c_out`=0. Internal registers and counter are cleared.
- Reset asserted mid-RUN aborts the operation. No `done` pulse follows and the outputs go to their reset values.
- Latency: with `start` accepted at edge T, `done` is high during the cycle after edge T+WIDTH. That is 64 edges for WIDTH=64.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accepting edge is T+WIDTH+2.
- `done` is high for exactly one cycle per accepted `start`.
- The operands `a`, `b` and `op` may change freely after the accepting edge.

## Test plan
- Reset mid-operation: accept add 5+7, deassert `rst_n` after 20 edges → immediately `ready`=1, `busy`=0, `result`=0, `cc`=000. No `done` pulse follows after release.
- Add with op=0, a=5, b=7 → `done` one cycle after edge T+64; `result`=12, `cc`=000, `c_out`=0. `busy` is high for exactly 64 cycles.
- Subtract equal values with op=1, a=b=3 → `result`=0, `cc`=100 (ZF), `c_out`=1.
- Signed overflow on add: a=0x7FFF_FFFF_FFFF_FFFF, b=1 → `result`=0x8000_0000_0000_0000, `cc`=011 (SF, OF), `c_out`=0.
- Borrow on subtract: op=1, a=0, b=1 → `result`=0xFFFF_FFFF_FFFF_FFFF, `cc`=010, `c_out`=0. Then op=1, a=0x8000_0000_0000_0000, b=1 → `result`=0x7FFF_FFFF_FFFF_FFFF, `cc`=001, `c_out`=1.
- Handshake:
  - `start` pulsed during RUN with different operands → ignored; the original result is reported.
  - `start` held high continuously → operations accepted every 66 cycles, one `done` pulse each, and `result` unchanged between pulses.

Source files
------------

// File: rtl/serial_addsub_if.sv
// Handshake and data bundle between the Execute-stage sequencer and the bit-serial add/subtract unit.
// The master drives the request; the slave returns status and the last completed result.
interface serial_addsub_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [2:0]       cc;
  logic             c_out;

  modport master (
    output start, op, a, b,
    input  ready, busy, done, result, cc, c_out
  );

  modport slave (
    input  start, op, a, b,
    output ready, busy, done, result, cc, c_out
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract: one full-adder cell, LSB first, one bit per clock.
// Produces {ZF, SF, OF} and the MSB carry on the edge that finishes the last bit.
module serial_addsub #(
  parameter int WIDTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_addsub_if.slave    bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-2:0] acc_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] result_reg;
  logic [2:0]       cc_reg;
  logic             c_out_reg;
  logic             ready_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    sum_bit    = a_reg[0] ^ b_reg[0] ^ carry_reg;
    carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);
    acc_next   = {sum_bit, acc_reg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      result_reg <= '0;
      cc_reg     <= 3'b000;
      c_out_reg  <= 1'b0;
      ready_reg  <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.a;
            // Subtraction is a + ~b + 1: invert b here and seed the carry with op.
            b_reg     <= bus.op ? ~bus.b : bus.b;
            carry_reg <= bus.op;
            cnt_reg   <= '0;
            state     <= RUN;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
          end
        end
        RUN: begin
          a_reg     <= {1'b0, a_reg[WIDTH-1:1]};
          b_reg     <= {1'b0, b_reg[WIDTH-1:1]};
          acc_reg   <= acc_next[WIDTH-1:1];
          carry_reg <= carry_next;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) begin
            result_reg <= acc_next;
            c_out_reg  <= carry_next;
            // carry_reg here is the carry into the MSB stage.
            cc_reg     <= {(acc_next == '0), sum_bit, carry_reg ^ carry_next};
            state      <= DONE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready  = ready_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.result = result_reg;
  assign bus.cc     = cc_reg;
  assign bus.c_out  = c_out_reg;
endmodule
